// File: rtl/mdu_pkg.sv
// mdu_pkg: shared RV32M op encoding, FSM states and datapath width for the multiply/divide unit.
package mdu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: one shift-add multiply or restoring-divide step per enable on unsigned magnitudes.
module mul_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  logic [W-1:0] m;
  logic [W:0] sum, sh, diff;
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  assign sh = {hi, lo[W-1]};
  assign diff = sh - {1'b0, m};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      m <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a;
      m <= b;
    end else if (step) begin
      hi <= is_div ? (diff[W] ? sh[W-1:0] : diff[W-1:0]) : sum[W:1];
      lo <= is_div ? {lo[W-2:0], !diff[W]} : {sum[0], lo[W-1:1]};
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide with register-file writeback.
// Define MDU_FAST_SPECIAL_EN to let divide-by-zero and signed overflow skip the iteration phase.
import mdu_pkg::*;
module mul_div_unit #(
  parameter int XLEN = mdu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            busy,
  output logic            we_out,
  output logic [4:0]      wa_out,
  output logic [XLEN-1:0] wd_out
);
  localparam int CW = $clog2(XLEN + 1);
  state_e state, state_nx;
  op_e op_in, op_q;
  logic [4:0] rd_q;
  logic [CW-1:0] cnt;
  logic neg_p, neg_r, b_zero, accept, fast, step, sa, sb, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, hi, lo, q_s, r_s, res;
  logic [2*XLEN-1:0] prod_s;
  assign op_in = op_e'(op);
  assign sa = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sb = op_in inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg = sa & a[XLEN-1];
  assign b_neg = sb & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign accept = state == IDLE && start && !flush;
  assign step = state == CALC && cnt != CW'(XLEN);
  assign busy = state != IDLE;
  assign we_out = state == DONE && rd_q != '0;
`ifdef MDU_FAST_SPECIAL_EN
  logic [XLEN-1:0] special;
  assign fast = op[2] && (b == '0 || (!op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && &b));
  assign special = b == '0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
`else
  assign fast = 1'b0;
`endif
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: state_nx = accept ? (fast ? DONE : CALC) : IDLE;
      CALC: state_nx = flush ? IDLE : (step ? CALC : DONE);
      default: state_nx = IDLE;
    endcase
  end
  mul_div_iter #(.W(XLEN)) u_iter (
    .clk(clk), .rst_n(rst_n), .load(accept), .step(step), .is_div(op_q[2]),
    .a(a_mag), .b(b_mag), .hi(hi), .lo(lo)
  );
  // Sign correction on the unsigned magnitudes; a zero divisor forces an all-ones quotient.
  assign prod_s = neg_p ? -{hi, lo} : {hi, lo};
  assign q_s = b_zero ? '1 : (neg_p ? -lo : lo);
  assign r_s = neg_r ? -hi : hi;
  assign res = op_q == OP_MUL ? prod_s[XLEN-1:0] :
               !op_q[2] ? prod_s[2*XLEN-1:XLEN] : (op_q[1] ? r_s : q_s);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= OP_MUL;
      rd_q <= '0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      b_zero <= 1'b0;
      cnt <= '0;
      wa_out <= '0;
      wd_out <= '0;
    end else begin
      if (accept) begin
        op_q <= op_in;
        rd_q <= rd;
        neg_p <= a_neg ^ b_neg;
        neg_r <= a_neg;
        b_zero <= b == '0;
      end
      cnt <= accept ? '0 : (step ? cnt + 1'b1 : cnt);
      if (state == CALC && state_nx == DONE) begin
        wa_out <= rd_q;
        wd_out <= res;
      end
`ifdef MDU_FAST_SPECIAL_EN
      if (accept && fast) begin
        wa_out <= rd;
        wd_out <= special;
      end
`endif
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic reference model.
import mdu_pkg::*;
module tb_mul_div_unit;
  logic clk, rst_n, start, flush, busy, we_out;
  logic [2:0] op;
  logic [31:0] a, b, wd_out;
  logic [4:0] rd, wa_out;
  int passed = 0, total = 0, failed = 0;
  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .flush(flush), .busy(busy), .we_out(we_out), .wa_out(wa_out), .wd_out(wd_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint uy = longint'({32'b0, y});
    logic [63:0] pu = {32'b0, x} * {32'b0, y};
    case (o)
      3'd0: return 32'(sx * sy);
      3'd1: return 32'((sx * sy) >>> 32);
      3'd2: return 32'((sx * uy) >>> 32);
      3'd3: return pu[63:32];
      3'd4: return y == 0 ? 32'hFFFF_FFFF : 32'(sx / sy);
      3'd5: return y == 0 ? 32'hFFFF_FFFF : x / y;
      3'd6: return y == 0 ? x : 32'(sx % sy);
      default: return y == 0 ? x : x % y;
    endcase
  endfunction
  function automatic int latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MDU_FAST_SPECIAL_EN
    if (o[2] && (y == 0 || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
`endif
    return 33;
  endfunction
  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd = r;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
    chk("busy_after_accept", busy, 1);
  endtask
  task automatic finish_op(input int lat, input logic [31:0] e, input logic [4:0] r, input string tag);
    int n = 0, seen = -1, wes = 0;
    logic [31:0] wd_c = 0;
    logic [4:0] wa_c = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (we_out) begin
        wes++;
        if (seen < 0) begin
          seen = n; wd_c = wd_out; wa_c = wa_out;
        end
      end
    end while (busy && n < 60);
    chk({tag, ".idle_edge"}, n, lat + 1);
    if (r != 0) begin
      chk({tag, ".data"}, wd_c, e);
      chk({tag, ".addr"}, wa_c, r);
      chk({tag, ".we_edge"}, seen, lat);
      chk({tag, ".pulses"}, wes, 1);
      chk({tag, ".hold"}, wd_out, e);
    end else chk({tag, ".no_we"}, wes, 0);
  endtask
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r, input string tag);
    start_op(o, x, y, r);
    finish_op(latency(o, x, y), ref_model(o, x, y), r, tag);
  endtask
  initial begin
    int wes;
    logic [2:0] o;
    logic [31:0] x, y;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 0; a = 0; b = 0; rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.we", we_out, 0);
    chk("rst.wa", wa_out, 0);
    chk("rst.wd", wd_out, 0);
    #1 rst_n = 1'b1;
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    finish_op(33, 32'hFFFF_FFEB, 5'd5, "mul_neg");
    chk("mul_neg.model", ref_model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh_min");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu_max");
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhsu_max");
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, "div_neg");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_neg");
    run(3'd5, 32'd100, 32'd7, 5'd7, "divu");
    run(3'd7, 32'd100, 32'd7, 5'd8, "remu");
    run(3'd5, 32'd5, 32'd0, 5'd9, "divu_zero");
    run(3'd7, 32'd5, 32'd0, 5'd10, "remu_zero");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf");
    run(3'd6, 32'hFFFF_FFF0, 32'd0, 5'd13, "rem_zero");
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run(o, x, y, 5'($urandom_range(1, 31)), "rand");
    end
    start_op(3'd5, 32'd1000, 32'd10, 5'd14);
    repeat (9) @(posedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; rd = 5'd15;
    @(posedge clk);
    #1 start = 1'b0;
    finish_op(23, 32'd100, 5'd14, "start_ignored");
    start_op(3'd0, 32'd9, 32'd9, 5'd16);
    repeat (20) @(posedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush.busy", busy, 0);
    wes = 0;
    repeat (40) begin
      @(posedge clk);
      #1 wes += int'(we_out);
    end
    chk("flush.no_we", wes, 0);
    chk("flush.wd_hold", wd_out, 32'd100);
    start_op(3'd0, 32'd6, 32'd7, 5'd17);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.we", we_out, 0);
    chk("arst.wa", wa_out, 0);
    chk("arst.wd", wd_out, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run(3'd3, 32'h0001_0000, 32'h0003_0000, 5'd18, "after_rst");
    run(3'd5, 32'd100, 32'd7, 5'd0, "rd_zero");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
